mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Load/store unit between the MEM stage of the RV32I pipeline and an external multi-cycle memory bus; it replaces the single-cycle data memory path. It takes the MEM-stage access (read/write strobes, funct3 mode, address, store data), performs byte-lane steering and a valid/ready bus transaction, stalls the pipeline for the duration, and returns sign/zero-extended load data. It also flags misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT, 256, max cycles in REQ+WAIT_RSP before abort; 0 disables the timeout.
CNT_W, $clog2(TIMEOUT+1), width of the timeout counter (derived).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
mem_read_m  in  1  MEM-stage load strobe
mem_write_m  in  1  MEM-stage store strobe
mode_m  in  3  funct3 of the MEM-stage instruction
addr_m  in  32  byte address (ALU result)
wdata_m  in  32  store data, unaligned, in low bits
load_data_m  out  32  extended load result; registered
stall_m  out  1  freeze IF..MEM stages this cycle
access_err_m  out  1  one-cycle pulse: misaligned, illegal, or timeout
bus_req_valid  out  1  request valid
bus_req_ready  in  1  request accepted
bus_req_we  out  1  1 = write
bus_req_addr  out  32  word address, {addr_m[31:2],2'b00}
bus_req_wdata  out  32  lane-replicated store data
bus_req_be  out  4  byte enables
bus_rsp_valid  in  1  read data valid; earliest one cycle after acceptance
bus_rsp_rdata  in  32  raw read word

Behaviour:
- Reset (async, rst_n=0): state IDLE; bus_req_valid=0, bus_req_we=0, bus_req_addr=0, bus_req_wdata=0, bus_req_be=0; load_data_m=0; timeout counter=0. An in-flight transaction is abandoned and a late bus_rsp_valid is ignored.
- FSM states:
  - IDLE: if a legal access is presented, stall_m=1 combinationally, the request is latched into the bus_req_* registers, and the FSM moves to REQ.
  - REQ: bus_req_valid=1 and all bus_req_* are held stable until bus_req_ready. On acceptance, a read goes to WAIT_RSP and a write goes to DONE.
  - WAIT_RSP: on bus_rsp_valid, the extended data is captured into load_data_m and the FSM moves to DONE.
  - DONE: stall_m=0 for exactly one cycle so the pipeline advances, then unconditional return to IDLE. Strobes still high in DONE never re-issue.
- stall_m = (IDLE & legal access) | REQ | WAIT_RSP.
- Minimum latency with zero-wait-state ready and response:
  - Load: 3 stall cycles, then DONE.
  - Store: 2 stall cycles, then DONE.
- Legal modes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Illegal or misaligned accesses:
  - Any other mode, half access with addr[0]=1, word access with addr[1:0]!=0, or read and write both asserted.
  - Response in IDLE: access_err_m=1 combinationally, stall_m=0, no bus transaction, load_data_m unchanged, the FSM stays in IDLE.
- Store lane steering:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata_m[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata_m[15:0]}}.
  - SW: be=4'b1111, wdata=wdata_m.
- Loads: bus_req_be=4'b1111. The selected byte or half is taken from bus_rsp_rdata by addr[1:0] latched at request time, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT_RSP.
  - When it reaches TIMEOUT, the FSM goes to DONE with access_err_m=1 in the DONE cycle and bus_req_valid dropped. A timed-out load sets load_data_m=0.
- bus_rsp_valid outside WAIT_RSP is ignored. bus_req_ready outside REQ is ignored.
- load_data_m holds its value until the next completed load.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum {IDLE, REQ, WAIT_RSP, DONE}.
  - Localparam BE_W=4.
- Sub-module lsu_align (combinational): store lane steering and byte enables, load extraction and extension, legality/misalign check. mem_stage_lsu holds the FSM, request registers and timeout counter.

Test Plan:
- LW at 0x100, ready immediate, response 0xDEADBEEF one cycle later -> stall_m high 3 cycles; DONE cycle gives load_data_m=0xDEADBEEF and stall_m=0.
- SB wdata=0x000000A5 at 0x203, ready after 2 wait cycles -> be=4'b1000, wdata=0xA5A5A5A5, addr=0x200, req fields stable while waiting, stall 4 cycles, one-cycle DONE.
- LB at 0x1 with rdata 0x0000_8000, then LBU with the same data -> 0xFFFFFF80, then 0x00000080.
- LH at 0x3 -> access_err_m=1, stall_m=0, bus_req_valid never asserted.
- LW with no response and TIMEOUT=8 -> after 8 cycles: DONE, access_err_m pulse, load_data_m=0; a late bus_rsp_valid is ignored.
- rst_n low during WAIT_RSP -> all outputs immediately at reset values; FSM in IDLE after release; a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the MEM-stage load/store unit:
//                funct3 access-size codes, FSM state type, byte-enable width.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // funct3 encodings for RV32I loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsuState_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Purely combinational helper for the load/store unit.
//                - Legality / alignment check of the presented access
//                - Store byte-lane replication and byte enables
//                - Load byte/half extraction with sign or zero extension
//  Ports       : accRead/accWrite/accMode/accAddrLo/storeData - live access
//                rspMode/rspAddrLo  - access attributes latched at request
//                rspWord            - raw bus read word
//                legal, laneBe, laneData, loadData - results
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic            accRead,
    input  logic            accWrite,
    input  logic [2:0]      accMode,
    input  logic [1:0]      accAddrLo,
    input  logic [31:0]     storeData,
    input  logic [2:0]      rspMode,
    input  logic [1:0]      rspAddrLo,
    input  logic [31:0]     rspWord,
    output logic            legal,
    output logic [BE_W-1:0] laneBe,
    output logic [31:0]     laneData,
    output logic [31:0]     loadData
);

    logic       w_modeOk;
    logic       w_alignOk;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    // Legality: exactly one strobe, a funct3 valid for that direction,
    // and natural alignment for the access size.
    always_comb begin
        w_modeOk  = 1'b0;
        w_alignOk = 1'b0;
        case (accMode)
            F3_B, F3_H, F3_W: w_modeOk = 1'b1;
            F3_BU, F3_HU:     w_modeOk = accRead;   // unsigned forms are load-only
            default:          w_modeOk = 1'b0;
        endcase
        case (accMode[1:0])
            2'b00:   w_alignOk = 1'b1;
            2'b01:   w_alignOk = ~accAddrLo[0];
            2'b10:   w_alignOk = (accAddrLo == 2'b00);
            default: w_alignOk = 1'b0;
        endcase
        legal = (accRead ^ accWrite) & w_modeOk & w_alignOk;
    end

    // Store steering: data is replicated across lanes so the memory only
    // needs the byte enables to pick the right bytes.
    always_comb begin
        laneBe   = 4'b1111;
        laneData = storeData;
        case (accMode[1:0])
            2'b00: begin
                laneBe   = 4'b0001 << accAddrLo;
                laneData = {4{storeData[7:0]}};
            end
            2'b01: begin
                laneBe   = accAddrLo[1] ? 4'b1100 : 4'b0011;
                laneData = {2{storeData[15:0]}};
            end
            default: begin
                laneBe   = 4'b1111;
                laneData = storeData;
            end
        endcase
        if (accRead) begin
            laneBe = 4'b1111;
        end
    end

    // Load extraction uses the address bits latched at request time, since
    // the pipeline inputs are not guaranteed to be meaningful by then.
    always_comb begin
        case (rspAddrLo)
            2'b00:   w_byte = rspWord[7:0];
            2'b01:   w_byte = rspWord[15:8];
            2'b10:   w_byte = rspWord[23:16];
            default: w_byte = rspWord[31:24];
        endcase
        w_half = rspAddrLo[1] ? rspWord[31:16] : rspWord[15:0];
        case (rspMode)
            F3_B:    loadData = {{24{w_byte[7]}}, w_byte};
            F3_H:    loadData = {{16{w_half[15]}}, w_half};
            F3_BU:   loadData = {24'h0, w_byte};
            F3_HU:   loadData = {16'h0, w_half};
            default: loadData = rspWord;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : Load/store unit bridging the RV32I MEM stage to a multi-cycle
//                valid/ready memory bus. Stalls the pipeline for the length of
//                the transaction and returns extended load data.
//  Ports       : clk, rst_n (async, active-low)
//                mem_read_m/mem_write_m/mode_m/addr_m/wdata_m - MEM-stage access
//                load_data_m, stall_m, access_err_m           - to pipeline
//                bus_req_* (valid/ready/we/addr/wdata/be)      - request channel
//                bus_rsp_valid/bus_rsp_rdata                   - response channel
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      mode_m,
    input  logic [31:0]     addr_m,
    input  logic [31:0]     wdata_m,
    output logic [31:0]     load_data_m,
    output logic            stall_m,
    output logic            access_err_m,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic            bus_req_we,
    output logic [31:0]     bus_req_addr,
    output logic [31:0]     bus_req_wdata,
    output logic [BE_W-1:0] bus_req_be,
    input  logic            bus_rsp_valid,
    input  logic [31:0]     bus_rsp_rdata
);

    localparam logic [CNT_W-1:0] c_toLast = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsuState_t        r_state;
    lsuState_t        w_nextState;
    logic             w_abort;
    logic             r_reqValid;
    logic             r_reqWe;
    logic [31:0]      r_reqAddr;
    logic [31:0]      r_reqWdata;
    logic [BE_W-1:0]  r_reqBe;
    logic [2:0]       r_ldMode;
    logic [1:0]       r_ldAddrLo;
    logic [31:0]      r_loadData;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timedOut;

    logic             w_access;
    logic             w_legal;
    logic             w_startLegal;
    logic             w_toHit;
    logic [BE_W-1:0]  w_laneBe;
    logic [31:0]      w_laneData;
    logic [31:0]      w_loadData;

    lsu_align u_align (
        .accRead   (mem_read_m),
        .accWrite  (mem_write_m),
        .accMode   (mode_m),
        .accAddrLo (addr_m[1:0]),
        .storeData (wdata_m),
        .rspMode   (r_ldMode),
        .rspAddrLo (r_ldAddrLo),
        .rspWord   (bus_rsp_rdata),
        .legal     (w_legal),
        .laneBe    (w_laneBe),
        .laneData  (w_laneData),
        .loadData  (w_loadData)
    );

    assign w_access     = mem_read_m | mem_write_m;
    assign w_startLegal = (r_state == IDLE) & w_access & w_legal;
    // Counter holds the number of REQ/WAIT_RSP cycles already completed, so
    // the cycle seen with c_toLast is the last one allowed.
    assign w_toHit      = (TIMEOUT != 0) && (r_cnt == c_toLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A read accepted in the final budgeted cycle has no time left for its
    // response, so it is aborted; an accepted write is already complete.
    always_comb begin
        w_nextState = r_state;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startLegal) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                if (bus_req_ready && r_reqWe) begin
                    w_nextState = DONE;
                end else if (w_toHit) begin
                    w_nextState = DONE;
                    w_abort     = 1'b1;
                end else if (bus_req_ready) begin
                    w_nextState = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus_rsp_valid) begin
                    w_nextState = DONE;
                end else if (w_toHit) begin
                    w_nextState = DONE;
                    w_abort     = 1'b1;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reqValid <= 1'b0;
            r_reqWe    <= 1'b0;
            r_reqAddr  <= 32'h0;
            r_reqWdata <= 32'h0;
            r_reqBe    <= '0;
            r_ldMode   <= 3'b000;
            r_ldAddrLo <= 2'b00;
            r_loadData <= 32'h0;
            r_cnt      <= '0;
            r_timedOut <= 1'b0;
        end else begin
            r_timedOut <= w_abort;
            case (r_state)
                IDLE: begin
                    if (w_startLegal) begin
                        r_reqValid <= 1'b1;
                        r_reqWe    <= mem_write_m;
                        r_reqAddr  <= {addr_m[31:2], 2'b00};
                        r_reqWdata <= w_laneData;
                        r_reqBe    <= w_laneBe;
                        r_ldMode   <= mode_m;
                        r_ldAddrLo <= addr_m[1:0];
                        r_cnt      <= '0;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_nextState != REQ) begin
                        r_reqValid <= 1'b0;
                    end
                    if (w_abort && !r_reqWe) begin
                        r_loadData <= 32'h0;
                    end
                end
                WAIT_RSP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_rsp_valid) begin
                        r_loadData <= w_loadData;
                    end else if (w_abort) begin
                        r_loadData <= 32'h0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_m       = w_startLegal | (r_state == REQ) | (r_state == WAIT_RSP);
    assign access_err_m  = ((r_state == IDLE) & w_access & ~w_legal) |
                           ((r_state == DONE) & r_timedOut);
    assign load_data_m   = r_loadData;
    assign bus_req_valid = r_reqValid;
    assign bus_req_we    = r_reqWe;
    assign bus_req_addr  = r_reqAddr;
    assign bus_req_wdata = r_reqWdata;
    assign bus_req_be    = r_reqBe;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_lsu
//  Description : Self-checking bench for mem_stage_lsu: directed scenarios
//                followed by randomized accesses against a transaction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read_m = 1'b0;
    logic        mem_write_m = 1'b0;
    logic [2:0]  mode_m = 3'b000;
    logic [31:0] addr_m = 32'h0;
    logic [31:0] wdata_m = 32'h0;
    logic [31:0] load_data_m;
    logic        stall_m;
    logic        access_err_m;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_be;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_rdata = 32'h0;

    int nCmp = 0;
    int nBad = 0;
    logic [31:0] expLoad = 32'h0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read_m    (mem_read_m),
        .mem_write_m   (mem_write_m),
        .mode_m        (mode_m),
        .addr_m        (addr_m),
        .wdata_m       (wdata_m),
        .load_data_m   (load_data_m),
        .stall_m       (stall_m),
        .access_err_m  (access_err_m),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_we    (bus_req_we),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_be    (bus_req_be),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit mdlLegal(bit rd, bit wr, logic [2:0] md, logic [1:0] a);
        int nb;
        bit modeOk;
        if (rd == wr) return 1'b0;
        modeOk = rd ? (md inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (md inside {3'd0, 3'd1, 3'd2});
        if (md[1:0] == 2'b11) return 1'b0;
        nb = 1 << md[1:0];
        return modeOk && ((int'(a) % nb) == 0);
    endfunction

    function automatic logic [3:0] mdlBe(bit rd, logic [2:0] md, logic [1:0] a);
        int nb;
        int b;
        nb = 1 << md[1:0];
        if (rd || nb >= 4) return 4'hF;
        b = ((1 << nb) - 1) << a;
        return b[3:0];
    endfunction

    function automatic logic [31:0] mdlWdata(logic [2:0] md, logic [31:0] wd);
        if (md[1:0] == 2'b00) return {24'h0, wd[7:0]} * 32'h01010101;
        if (md[1:0] == 2'b01) return {16'h0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] mdlLoad(logic [2:0] md, logic [1:0] a, logic [31:0] w);
        int nb;
        logic [31:0] v;
        logic [31:0] mask;
        nb = 1 << md[1:0];
        if (nb >= 4) return w;
        v    = w >> (8 * a);
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v    = v & mask;
        if (!md[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // One pipeline access: strobes held until the cycle stall_m drops, with
    // a bus slave that accepts after rdyDly valid cycles and answers reads
    // rspDly cycles after acceptance.
    task automatic runTxn(input bit rd, input bit wr, input logic [2:0] md,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int rdyDly, input int rspDly, input logic [31:0] rdata);
        bit legal;
        int lat;
        int expStall;
        bit expErr;
        int stallCnt;
        int vSeen;
        int since;
        bit accepted;
        bit finished;
        bit accNow;
        legal = mdlLegal(rd, wr, md, a[1:0]);
        lat   = rdyDly + 1 + (rd ? rspDly : 0);
        if (!legal) begin
            expStall = 0;
            expErr   = 1'b1;
        end else if (lat <= TO) begin
            expStall = 1 + lat;
            expErr   = 1'b0;
            if (rd) expLoad = mdlLoad(md, a[1:0], rdata);
        end else begin
            expStall = 1 + TO;
            expErr   = 1'b1;
            if (rd) expLoad = 32'h0;
        end

        @(negedge clk);
        mem_read_m  = rd;
        mem_write_m = wr;
        mode_m      = md;
        addr_m      = a;
        wdata_m     = wd;
        stallCnt = 0; vSeen = 0; since = 0; accepted = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            #1;
            if (!stall_m) begin
                finished = 1'b1;
                break;
            end
            stallCnt++;
            if (bus_req_valid) begin
                chk("req_addr", bus_req_addr, {a[31:2], 2'b00});
                chk("req_we", 32'(bus_req_we), 32'(wr));
                chk("req_be", 32'(bus_req_be), 32'(mdlBe(rd, md, a[1:0])));
                if (wr) chk("req_wdata", bus_req_wdata, mdlWdata(md, wd));
            end
            bus_req_ready = bus_req_valid && (vSeen == rdyDly);
            bus_rsp_valid = rd && accepted && (since == rspDly);
            bus_rsp_rdata = bus_rsp_valid ? rdata : $urandom;
            accNow = bus_req_valid && bus_req_ready;
            if (bus_req_valid) vSeen++;
            @(posedge clk);
            if (accNow) begin
                accepted = 1'b1;
                since    = 1;
            end else if (accepted) begin
                since++;
            end
            @(negedge clk);
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
        end
        chk("finished", 32'(finished), 32'd1);
        chk("stall_cycles", 32'(stallCnt), 32'(expStall));
        chk("access_err", 32'(access_err_m), 32'(expErr));
        chk("valid_at_end", 32'(bus_req_valid), 32'd0);
        chk("load_data", load_data_m, expLoad);
    endtask

    task automatic idleCycle();
        @(negedge clk);
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
        #1;
        chk("idle_stall", 32'(stall_m), 32'd0);
        chk("idle_err", 32'(access_err_m), 32'd0);
    endtask

    initial begin
        bit rd;
        bit wr;
        int sel;
        logic [2:0] md;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_we", 32'(bus_req_we), 32'd0);
        chk("rst_addr", bus_req_addr, 32'h0);
        chk("rst_wdata", bus_req_wdata, 32'h0);
        chk("rst_be", 32'(bus_req_be), 32'd0);
        chk("rst_load", load_data_m, 32'h0);
        chk("rst_stall", 32'(stall_m), 32'd0);
        rst_n = 1'b1;

        // LW, zero-wait bus
        runTxn(1, 0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
        // SB at 0x203, two wait cycles
        runTxn(0, 1, 3'b000, 32'h203, 32'h000000A5, 2, 1, 32'h0);
        // LB / LBU at 0x1
        runTxn(1, 0, 3'b000, 32'h1, 32'h0, 0, 1, 32'h00008000);
        runTxn(1, 0, 3'b100, 32'h1, 32'h0, 0, 1, 32'h00008000);
        // misaligned LH
        runTxn(1, 0, 3'b001, 32'h3, 32'h0, 0, 1, 32'h0);
        // LW timeout, then a late response must be ignored
        runTxn(1, 0, 3'b010, 32'h40, 32'h0, 0, 50, 32'h11111111);
        @(negedge clk);
        mem_read_m    = 1'b0;
        mem_write_m   = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h12345678;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        #1;
        chk("late_rsp_load", load_data_m, 32'h0);
        chk("late_rsp_stall", 32'(stall_m), 32'd0);

        // reset asserted while waiting for a read response
        runTxn(1, 0, 3'b010, 32'h80, 32'h0, 0, 1, 32'hCAFEF00D);
        @(negedge clk);
        mem_read_m = 1'b1; mode_m = 3'b010; addr_m = 32'h44;
        @(negedge clk);
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        mem_read_m = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h55AA55AA;
        #1;
        expLoad = 32'h0;
        chk("arst_valid", 32'(bus_req_valid), 32'd0);
        chk("arst_addr", bus_req_addr, 32'h0);
        chk("arst_be", 32'(bus_req_be), 32'd0);
        chk("arst_load", load_data_m, 32'h0);
        chk("arst_stall", 32'(stall_m), 32'd0);
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        rst_n = 1'b1;
        runTxn(1, 0, 3'b010, 32'h48, 32'h0, 1, 2, 32'h0BADC0DE);

        // randomized accesses
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel <= 4) || (sel == 9);
            wr  = (sel >= 5);
            if ($urandom_range(0, 3) != 0) begin
                sel = $urandom_range(0, 4);
                md  = (sel == 3) ? 3'b100 : (sel == 4) ? 3'b101 : 3'(sel);
            end else begin
                md = 3'($urandom_range(0, 7));
            end
            runTxn(rd, wr, md, $urandom, $urandom, $urandom_range(0, 9),
                   $urandom_range(1, 5), $urandom);
            if ($urandom_range(0, 7) == 0) idleCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
